// File: rtl/thor2023_dcache_fill_ctrl_if.sv
// Wishbone-style fill bus between the Thor2023 dcache fill sequencer and memory.
// The master drives cyc/stb/adr; the slave returns ack/err and beat data.
interface thor2023_dcache_fill_ctrl_if #(
    parameter int unsigned ADR_WID = 32,
    parameter int unsigned BUS_WID = 128
);
    logic               cyc_o;
    logic               stb_o;
    logic [ADR_WID-1:0] adr_o;
    logic               ack_i;
    logic               err_i;
    logic [BUS_WID-1:0] dat_i;

    modport master (
        output cyc_o, stb_o, adr_o,
        input  ack_i, err_i, dat_i
    );

    modport slave (
        input  cyc_o, stb_o, adr_o,
        output ack_i, err_i, dat_i
    );
endinterface

// File: rtl/thor2023_dcache_fill_ctrl.sv
// Thor2023 dcache line-fill sequencer: hit lookup, then up to two 4-beat line fills per request.
// Define THOR2023_DCFILL_TIMEOUT_EN to abort a fill after TIMEOUT consecutive cycles without ack.
module thor2023_dcache_fill_ctrl #(
    parameter int unsigned ADR_WID  = 32,
    parameter int unsigned LINE_WID = 512,
    parameter int unsigned BUS_WID  = 128,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_v,
    output logic                        req_rdy,
    input  logic [ADR_WID-1:0]          req_adr,
    input  logic                        req_span,
    input  logic                        hite,
    input  logic                        hito,
    thor2023_dcache_fill_ctrl_if.master bus,
    output logic                        wr_dc,
    output logic [ADR_WID-1:0]          update_adr,
    output logic [LINE_WID-1:0]         line_o,
    output logic                        done_o,
    output logic                        err_o
);
    localparam int unsigned Beats = LINE_WID / BUS_WID;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StFill,
        StWrite,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [ADR_WID-1:0]    line_q, line_d;
    logic [1:0]            beat_q, beat_d;
    logic                  span_q, span_d;
    logic                  pend_q, pend_d;
    logic [LINE_WID-1:0]   buf_q, buf_d;
    logic [ADR_WID-1:0]    upd_q, upd_d;
    logic                  rdy_q, cyc_q, wr_q, done_q, err_q;
    logic [ADR_WID-1:0]    adr_q;
    logic                  hit0, hit1;
    logic                  tmo_hit;
    logic                  fill_abort;

    // Bit 6 selects the bank; the following line always lives in the other bank.
    assign hit0 = line_q[6] ? hito : hite;
    assign hit1 = line_q[6] ? hite : hito;

`ifdef THOR2023_DCFILL_TIMEOUT_EN
    logic [7:0] tmo_q, tmo_d;

    always_comb begin
        tmo_d   = '0;
        tmo_hit = 1'b0;
        if (state_q == StFill && !bus.ack_i) begin
            tmo_d   = tmo_q + 8'd1;
            tmo_hit = (tmo_d == 8'(TIMEOUT));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_tmo;
    assign tmo_hit    = 1'b0;
    assign unused_tmo = ^32'(TIMEOUT);
`endif

    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        beat_d     = beat_q;
        span_d     = span_q;
        pend_d     = pend_q;
        buf_d      = buf_q;
        upd_d      = upd_q;
        fill_abort = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_v) begin
                    line_d  = {req_adr[ADR_WID-1:6], 6'b000000};
                    span_d  = req_span;
                    state_d = StLookup;
                end
            end
            StLookup: begin
                beat_d = '0;
                if (!hit0) begin
                    pend_d  = span_q & ~hit1;
                    state_d = StFill;
                end else if (span_q && !hit1) begin
                    line_d  = line_q + ADR_WID'(64);
                    pend_d  = 1'b0;
                    state_d = StFill;
                end else begin
                    state_d = StDone;
                end
            end
            StFill: begin
                // Error wins over a simultaneous ack; the beat is not stored.
                if (bus.err_i || tmo_hit) begin
                    fill_abort = 1'b1;
                    state_d    = StIdle;
                end else if (bus.ack_i) begin
                    for (int unsigned i = 0; i < Beats; i++) begin
                        if (beat_q == 2'(i)) begin
                            buf_d[i*BUS_WID +: BUS_WID] = bus.dat_i;
                        end
                    end
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        upd_d   = line_q;
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                if (pend_q) begin
                    line_d  = line_q + ADR_WID'(64);
                    pend_d  = 1'b0;
                    beat_d  = '0;
                    state_d = StFill;
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            line_q  <= '0;
            beat_q  <= '0;
            span_q  <= 1'b0;
            pend_q  <= 1'b0;
            buf_q   <= '0;
            upd_q   <= '0;
            rdy_q   <= 1'b1;
            cyc_q   <= 1'b0;
            adr_q   <= '0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            beat_q  <= beat_d;
            span_q  <= span_d;
            pend_q  <= pend_d;
            buf_q   <= buf_d;
            upd_q   <= upd_d;
            rdy_q   <= (state_d == StIdle);
            cyc_q   <= (state_d == StFill);
            adr_q   <= (state_d == StFill) ? line_d + ADR_WID'({beat_d, 4'b0000}) : '0;
            wr_q    <= (state_d == StWrite);
            done_q  <= (state_d == StDone);
            err_q   <= fill_abort;
        end
    end

    assign req_rdy    = rdy_q;
    assign bus.cyc_o  = cyc_q;
    assign bus.stb_o  = cyc_q;
    assign bus.adr_o  = adr_q;
    assign wr_dc      = wr_q;
    assign update_adr = upd_q;
    assign line_o     = buf_q;
    assign done_o     = done_q;
    assign err_o      = err_q;

endmodule
